// File: rtl/trng_pkg.sv
// Shared constants and types for the TRNG word generator and its debiaser.
package trng_pkg;

    localparam int TRNG_NUM_RO      = 4;
    localparam int TRNG_WIDTH       = 8;
    localparam int TRNG_SYNC_STAGES = 2;
    localparam int TRNG_RCT_LIMIT   = 32;

    typedef enum logic {
        VN_PHASE_FIRST,
        VN_PHASE_SECOND
    } vn_phase_t;

endpackage

// File: rtl/trng_vn_debias.sv
// Von Neumann debiaser: pairs raw samples, emits the first bit of each unequal pair.
module trng_vn_debias
    import trng_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic sample_valid,
    input  logic sample_bit,
    input  logic bypass,
    output logic bit_valid,
    output logic bit_out
);

    vn_phase_t phase;
    logic      first_bit;

    // Emission is combinational so a completed pair reaches the packer on the same edge.
    always_comb begin
        bit_valid = 1'b0;
        bit_out   = first_bit;
        if (sample_valid) begin
            if (bypass) begin
                bit_valid = 1'b1;
                bit_out   = sample_bit;
            end else if (phase == VN_PHASE_SECOND && first_bit != sample_bit) begin
                bit_valid = 1'b1;
            end
        end
    end

    // Bypass pins the phase to FIRST, so toggling the mode always restarts pairing cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase     <= VN_PHASE_FIRST;
            first_bit <= 1'b0;
        end else if (flush || bypass) begin
            phase <= VN_PHASE_FIRST;
        end else if (sample_valid) begin
            if (phase == VN_PHASE_FIRST) begin
                first_bit <= sample_bit;
                phase     <= VN_PHASE_SECOND;
            end else begin
                phase <= VN_PHASE_FIRST;
            end
        end
    end

endmodule

// File: rtl/trng_word_gen.sv
// Ring-oscillator TRNG: synchronise and XOR RO inputs, debias, pack into words,
// and guard the raw stream with a sticky repetition-count health test.
module trng_word_gen
    import trng_pkg::*;
#(
    parameter int NUM_RO      = TRNG_NUM_RO,
    parameter int WIDTH       = TRNG_WIDTH,
    parameter int SYNC_STAGES = TRNG_SYNC_STAGES,
    parameter int RCT_LIMIT   = TRNG_RCT_LIMIT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic [NUM_RO-1:0] ro_in,
    input  logic              vn_bypass,
    output logic [WIDTH-1:0]  rnd_data,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic              health_fail
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int RCT_W = $clog2(RCT_LIMIT + 1);

    logic [NUM_RO-1:0] sync_q [SYNC_STAGES];
    logic              raw_bit;
    logic              sample_valid;
    logic              last_sample;
    logic [RCT_W-1:0]  rct_cnt;
    logic [RCT_W-1:0]  rct_next;
    logic [WIDTH-1:0]  acc;
    logic [CNT_W-1:0]  bit_cnt;
    logic              word_full;
    logic              slot_free;
    logic              take_bit;
    logic              bit_valid;
    logic              bit_out;

    assign raw_bit      = ^sync_q[SYNC_STAGES-1];
    assign sample_valid = en & ~health_fail;
    assign rct_next     = (rct_cnt != '0 && raw_bit == last_sample) ? rct_cnt + RCT_W'(1) : RCT_W'(1);
    assign word_full    = (bit_cnt == CNT_W'(WIDTH));
    assign slot_free    = ~rnd_valid | rnd_ready;
    // A bit arriving while the full word moves out starts the next word.
    assign take_bit     = bit_valid & (~word_full | slot_free);

    trng_vn_debias u_debias (
        .clk          (clk),
        .rst          (rstn),
        .flush        (~en),
        .sample_valid (sample_valid),
        .sample_bit   (raw_bit),
        .bypass       (vn_bypass),
        .bit_valid    (bit_valid),
        .bit_out      (bit_out)
    );

    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            last_sample <= 1'b0;
            rct_cnt     <= '0;
            acc         <= '0;
            bit_cnt     <= '0;
            rnd_data    <= '0;
            rnd_valid   <= 1'b0;
            health_fail <= 1'b0;
        end else begin
            sync_q[0] <= ro_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];

            if (sample_valid) begin
                last_sample <= raw_bit;
                rct_cnt     <= rct_next;
                if (rct_next == RCT_W'(RCT_LIMIT)) health_fail <= 1'b1;
            end

            if (health_fail) begin
                rnd_valid <= 1'b0;
                rnd_data  <= '0;
                acc       <= '0;
                bit_cnt   <= '0;
            end else begin
                if (word_full && slot_free) begin
                    rnd_data  <= acc;
                    rnd_valid <= 1'b1;
                end else if (rnd_valid && rnd_ready) begin
                    rnd_valid <= 1'b0;
                end

                if (take_bit) begin
                    acc     <= {acc[WIDTH-2:0], bit_out};
                    bit_cnt <= word_full ? CNT_W'(1) : bit_cnt + CNT_W'(1);
                end else if (word_full && slot_free) begin
                    bit_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_trng_word_gen.sv
// Self-checking bench for trng_word_gen: directed scenarios plus random traffic against a queue-based model.
module tb_trng_word_gen;
    import trng_pkg::*;

    localparam int NUM_RO = TRNG_NUM_RO;
    localparam int WIDTH  = TRNG_WIDTH;
    localparam int SYNC   = TRNG_SYNC_STAGES;
    localparam int LIMIT  = TRNG_RCT_LIMIT;

    logic              clk = 1'b0;
    logic              rstn = 1'b1;
    logic              en = 1'b0;
    logic [NUM_RO-1:0] ro_in = '0;
    logic              vn_bypass = 1'b1;
    logic [WIDTH-1:0]  rnd_data;
    logic              rnd_valid;
    logic              rnd_ready = 1'b0;
    logic              health_fail;

    int n_checks = 0;
    int n_fail   = 0;

    trng_word_gen #(
        .NUM_RO      (NUM_RO),
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC),
        .RCT_LIMIT   (LIMIT)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .en          (en),
        .ro_in       (ro_in),
        .vn_bypass   (vn_bypass),
        .rnd_data    (rnd_data),
        .rnd_valid   (rnd_valid),
        .rnd_ready   (rnd_ready),
        .health_fail (health_fail)
    );

    always #5 clk = ~clk;

    // Reference model state: raw delay line, pending half pair, run length, bit list, output slot.
    bit         m_hist[$];
    bit         m_half_v, m_half, m_last, m_hf, m_valid;
    int         m_run;
    bit         m_acc[$];
    logic [31:0] m_data;
    logic [31:0] got[$];
    bit         seq[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NUM_RO-1:0] mk_ro(input bit b);
        logic [NUM_RO-1:0] r;
        r = NUM_RO'($urandom);
        if ((^r) != b) r[0] = ~r[0];
        return r;
    endfunction

    function automatic logic [31:0] pack_bits();
        logic [31:0] v = 0;
        foreach (m_acc[i]) v = v * 2 + m_acc[i];
        return v;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
        m_half_v = 0; m_half = 0; m_last = 0; m_hf = 0; m_valid = 0;
        m_run = 0; m_acc.delete(); m_data = 0;
    endtask

    task automatic model_edge(input bit r, input bit e, input logic [NUM_RO-1:0] ro, input bit byp, input bit rdy);
        bit raw, emit, ebit, newhf;
        if (r) begin
            model_reset();
            return;
        end
        raw = m_hist[SYNC-1];
        emit = 0; ebit = 0; newhf = 0;
        if (e && !m_hf) begin
            if (byp) begin
                emit = 1; ebit = raw;
            end else if (!m_half_v) begin
                m_half_v = 1; m_half = raw;
            end else begin
                m_half_v = 0;
                if (m_half != raw) begin emit = 1; ebit = m_half; end
            end
            if (m_run > 0 && raw == m_last) m_run++; else m_run = 1;
            m_last = raw;
            if (m_run == LIMIT) newhf = 1;
        end
        if (!e || byp) m_half_v = 0;
        if (m_hf) begin
            m_valid = 0; m_data = 0; m_acc.delete();
        end else begin
            if (m_acc.size() == WIDTH && (!m_valid || rdy)) begin
                m_data = pack_bits(); m_valid = 1; m_acc.delete();
            end else if (m_valid && rdy) begin
                m_valid = 0;
            end
            if (emit && m_acc.size() < WIDTH) m_acc.push_back(ebit);
        end
        m_hf = m_hf | newhf;
        m_hist.push_front(^ro);
        void'(m_hist.pop_back());
    endtask

    task automatic step(input bit r, input bit e, input logic [NUM_RO-1:0] ro, input bit byp, input bit rdy);
        rstn = r; en = e; ro_in = ro; vn_bypass = byp; rnd_ready = rdy;
        if (!r && rnd_valid && rnd_ready) got.push_back(32'(rnd_data));
        @(posedge clk);
        model_edge(r, e, ro, byp, rdy);
        #1;
        check_eq("valid", 32'(rnd_valid), 32'(m_valid));
        check_eq("data", 32'(rnd_data), m_data);
        check_eq("health", 32'(health_fail), 32'(m_hf));
    endtask

    // Samples seq[k] lands SYNC cycles after it is driven, so en rises SYNC cycles late.
    task automatic feed(input bit byp, input bit rdy);
        for (int k = 0; k < seq.size() + SYNC; k++)
            step(0, k >= SYNC, mk_ro(k < seq.size() ? seq[k] : 1'b0), byp, rdy);
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) seq.push_back(b[i]);
    endtask

    task automatic do_reset(input bit byp);
        step(1, 0, '0, byp, 1);
        step(1, 0, '0, byp, 1);
        got.delete();
    endtask

    task automatic idle(input int n, input bit byp, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, mk_ro($urandom_range(0, 1)), byp, rdy);
    endtask

    function automatic logic [31:0] word_at(input int i);
        return (got.size() > i) ? got[i] : 32'hFFFF_FFFF;
    endfunction

    initial begin
        logic [7:0] r1, r2, r3;
        bit byp, rdy, rr, ee;

        do_reset(1);
        check_eq("reset_valid", 32'(rnd_valid), 0);
        check_eq("reset_data", 32'(rnd_data), 0);
        check_eq("reset_health", 32'(health_fail), 0);

        // Bypass packing
        seq.delete(); push_byte(8'hB2);
        feed(1, 1);
        idle(3, 1, 1);
        check_eq("t1_count", got.size(), 1);
        check_eq("t1_word", word_at(0), 32'hB2);

        // Von Neumann mode
        do_reset(0);
        seq = '{0,1, 1,0, 0,0, 1,1, 1,0, 0,1, 1,0, 1,0, 0,1, 1,0};
        feed(0, 1);
        idle(3, 0, 1);
        check_eq("t2_count", got.size(), 1);
        check_eq("t2_word", word_at(0), 32'h6D);

        // Backpressure
        do_reset(1);
        r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
        seq.delete(); push_byte(r1); push_byte(r2); push_byte(r3);
        feed(1, 0);
        idle(2, 1, 0);
        check_eq("t3_hold_valid", 32'(rnd_valid), 1);
        check_eq("t3_hold_data", 32'(rnd_data), 32'(r1));
        idle(1, 1, 1);
        check_eq("t3_second_valid", 32'(rnd_valid), 1);
        check_eq("t3_second_data", 32'(rnd_data), 32'(r2));
        idle(3, 1, 1);
        check_eq("t3_count", got.size(), 2);
        check_eq("t3_first", word_at(0), 32'(r1));
        check_eq("t3_second", word_at(1), 32'(r2));

        // Health failure on a stuck raw stream
        do_reset(1);
        seq.delete();
        for (int i = 0; i < LIMIT; i++) seq.push_back(1'b0);
        feed(1, 1);
        check_eq("t4_health_set", 32'(health_fail), 1);
        step(0, 1, mk_ro(1'b1), 1, 1);
        check_eq("t4_valid_low", 32'(rnd_valid), 0);
        for (int i = 0; i < 10; i++) step(0, 1, mk_ro($urandom_range(0, 1)), 1, 1);
        check_eq("t4_count", got.size(), LIMIT / WIDTH - 1);
        check_eq("t4_sticky", 32'(health_fail), 1);
        step(1, 0, '0, 1, 1);
        check_eq("t4_cleared", 32'(health_fail), 0);

        // Reset in the middle of a word
        do_reset(1);
        seq.delete();
        for (int i = 0; i < 5; i++) seq.push_back(1'($urandom));
        feed(1, 1);
        step(1, 0, '0, 1, 1);
        seq.delete(); push_byte(8'hA5);
        feed(1, 1);
        idle(3, 1, 1);
        check_eq("t5_count", got.size(), 1);
        check_eq("t5_word", word_at(0), 32'hA5);

        // Enable gating discards a half pair
        do_reset(0);
        seq = '{1};
        feed(0, 1);
        idle(3, 0, 1);
        seq = '{0,1, 1,0, 1,0, 1,0, 1,0, 1,0, 1,0, 1,0};
        feed(0, 1);
        idle(3, 0, 1);
        check_eq("t6_count", got.size(), 1);
        check_eq("t6_word", word_at(0), 32'h7F);

        // Random traffic against the model
        do_reset(1);
        byp = 1;
        for (int i = 0; i < 3000; i++) begin
            rr = ($urandom_range(0, 499) == 0);
            ee = ($urandom_range(0, 9) != 0);
            rdy = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 49) == 0) byp = ~byp;
            step(rr, ee, NUM_RO'($urandom), byp, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
